// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: response-owner tags and priority-FSM states.
// Also provides the wait-counter width helper used by the priority FSM.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   typedef enum logic {
      DATA_PRI = 1'b0,
      INST_PRI = 1'b1
   } prio_state_t;

   function automatic int wait_cnt_width(input int max_wait);
      return $clog2(max_wait) + 1;
   endfunction

endpackage

// File: rtl/sram_arbiter_arb_prio_fsm.sv
// Priority FSM: data side wins conflicts until fetch has been denied MAX_WAIT times in a row.
// Latency: if_prio is registered and changes the cycle after the deciding denial/grant.
// Backpressure: none; it only observes request/grant activity.
module arb_prio_fsm
   import sram_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic dm_req,
   input  logic if_gnt,
   output logic if_prio
);

   localparam int CNT_W = wait_cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] LAST_DENIAL = CNT_W'(MAX_WAIT - 1);

   prio_state_t      state;
   logic [CNT_W-1:0] wait_cnt;
   logic             if_denied;

   // A fetch can only lose to the data side, so a denial always coincides with dm_req.
   assign if_denied = if_req & dm_req & ~if_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DATA_PRI;
         wait_cnt <= '0;
         if_prio  <= 1'b0;
      end else begin
         if (if_gnt) begin
            wait_cnt <= '0;
         end else if (if_denied && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         case (state)
            DATA_PRI: begin
               if (if_denied && (wait_cnt == LAST_DENIAL)) begin
                  state   <= INST_PRI;
                  if_prio <= 1'b1;
               end
            end
            INST_PRI: begin
               if (if_gnt) begin
                  state   <= DATA_PRI;
                  if_prio <= 1'b0;
               end
            end
            default: begin
               state   <= DATA_PRI;
               if_prio <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between fetch and data ports; optional ARB_PERF_CNT_EN adds perf counters.
// Latency: grant combinational, read data/rvalid one cycle after grant; 1 access/cycle throughput.
// Backpressure: loser is held off by withholding its gnt; stallreq_arb flags any waiting request.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic [DATA_W/8-1:0] dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stallreq_arb
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [63:0]         perf_conflict,
   output logic [63:0]         perf_if_stall
`endif
);

   logic   if_prio;
   owner_t owner;
   logic   dm_wr_q;

   arb_prio_fsm #(.MAX_WAIT(MAX_WAIT)) u_prio_fsm (
      .clk     (clk),
      .rst     (rst),
      .if_req  (if_req),
      .dm_req  (dm_req),
      .if_gnt  (if_gnt),
      .if_prio (if_prio)
   );

   assign if_gnt = ~rst & if_req & (~dm_req | if_prio);
   assign dm_gnt = ~rst & dm_req & ~(if_req & if_prio);

   assign stallreq_arb = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

   assign mem_en    = if_gnt | dm_gnt;
   assign mem_we    = dm_gnt ? dm_we : '0;
   assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
   assign mem_wdata = dm_gnt ? dm_wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= OWN_NONE;
         dm_wr_q <= 1'b0;
      end else begin
         owner   <= if_gnt ? OWN_IF : (dm_gnt ? OWN_DM : OWN_NONE);
         dm_wr_q <= dm_gnt & (|dm_we);
      end
   end

   // Gating with rst drops a response that would land in a reset cycle.
   assign if_rvalid = ~rst & (owner == OWN_IF);
   assign dm_rvalid = ~rst & (owner == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = (dm_rvalid & ~dm_wr_q) ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_conflict <= '0;
         perf_if_stall <= '0;
      end else begin
         if (if_req && dm_req && (perf_conflict != '1)) perf_conflict <= perf_conflict + 64'd1;
         if (if_req && !if_gnt && (perf_if_stall != '1)) perf_if_stall <= perf_if_stall + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a denial-count reference model and a pattern SRAM.
module tb_sram_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int BW = DW / 8;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic [BW-1:0] dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic [BW-1:0] mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          stallreq_arb;
`ifdef ARB_PERF_CNT_EN
   logic [63:0]   perf_conflict;
   logic [63:0]   perf_if_stall;
`endif

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_rdata     (if_rdata),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_gnt       (dm_gnt),
      .dm_rvalid    (dm_rvalid),
      .dm_rdata     (dm_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .stallreq_arb (stallreq_arb)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_conflict (perf_conflict),
      .perf_if_stall (perf_if_stall)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pat(input logic [63:0] a);
      return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   // SRAM stand-in: reads return a pattern of the address, anything else returns junk.
   always @(posedge clk) begin
      if (mem_en && (mem_we == '0)) mem_rdata <= pat(mem_addr);
      else                          mem_rdata <= {$urandom, $urandom};
   end

   // Reference model: fetch has priority once it has lost MAX_WAIT times since its last grant.
   int            denials = 0;
   bit            pend_if = 0, pend_dm = 0;
   logic [63:0]   pend_if_dat = '0, pend_dm_dat = '0;
   longint        n_conflict = 0, n_if_stall = 0;

   task automatic new_if(input int p);
      if_req  = ($urandom_range(99) < p);
      if_addr = {$urandom, $urandom} & ~64'h7;
   endtask

   task automatic new_dm(input int p);
      dm_req   = ($urandom_range(99) < p);
      dm_we    = ($urandom_range(1) == 0) ? '0 : BW'($urandom);
      dm_addr  = {$urandom, $urandom} & ~64'h7;
      dm_wdata = {$urandom, $urandom};
   endtask

   task automatic step(input int p_if, input int p_dm, input int p_rst);
      bit e_if, e_dm, prio;
      @(negedge clk);
      prio = (denials >= MW);
      e_if = !rst && if_req && (!dm_req || prio);
      e_dm = !rst && dm_req && !(if_req && prio);
      chk("if_gnt", 64'(if_gnt), 64'(e_if));
      chk("dm_gnt", 64'(dm_gnt), 64'(e_dm));
      chk("stallreq_arb", 64'(stallreq_arb), 64'((if_req && !e_if) || (dm_req && !e_dm)));
      chk("mem_en", 64'(mem_en), 64'(e_if || e_dm));
      chk("mem_we", 64'(mem_we), e_dm ? 64'(dm_we) : 64'd0);
      if (e_dm) begin
         chk("mem_addr_dm", mem_addr, dm_addr);
         chk("mem_wdata", mem_wdata, dm_wdata);
      end else if (e_if) begin
         chk("mem_addr_if", mem_addr, if_addr);
      end
      chk("if_rvalid", 64'(if_rvalid), 64'(pend_if && !rst));
      chk("if_rdata", if_rdata, (pend_if && !rst) ? pend_if_dat : 64'd0);
      chk("dm_rvalid", 64'(dm_rvalid), 64'(pend_dm && !rst));
      chk("dm_rdata", dm_rdata, (pend_dm && !rst) ? pend_dm_dat : 64'd0);

      @(posedge clk);
      if (rst) begin
         denials = 0;
         pend_if = 0;
         pend_dm = 0;
         n_conflict = 0;
         n_if_stall = 0;
      end else begin
         if (e_if)        denials = 0;
         else if (if_req) denials++;
         if (if_req && dm_req) n_conflict++;
         if (if_req && !e_if)  n_if_stall++;
         pend_if     = e_if;
         pend_if_dat = pat(if_addr);
         pend_dm     = e_dm;
         pend_dm_dat = (|dm_we) ? 64'd0 : pat(dm_addr);
      end

      #1;
      if (!(if_req && !e_if)) new_if(p_if);
      if (!(dm_req && !e_dm)) new_dm(p_dm);
      rst = ($urandom_range(99) < p_rst);
   endtask

   task automatic run(input int n, input int p_if, input int p_dm, input int p_rst);
      for (int i = 0; i < n; i++) step(p_if, p_dm, p_rst);
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
      run(3, 0, 0, 100);
      run(1, 100, 0, 0);
      run(20, 60, 0, 0);
      run(20, 0, 60, 0);
      run(40, 100, 100, 0);
      run(400, 50, 50, 3);
      run(300, 85, 85, 0);
      run(200, 100, 0, 1);
      run(200, 90, 90, 0);
`ifdef ARB_PERF_CNT_EN
      @(negedge clk);
      chk("perf_conflict", perf_conflict, 64'(n_conflict));
      chk("perf_if_stall", perf_if_stall, 64'(n_if_stall));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
